// File: rtl/aludec_pkg.sv
// Shared constants and types for the sequenced ALU-control decoder:
// aluop classes, funct encodings, ALU control codes and FSM states.
package aludec_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_LI    = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_ZFR  = 6'b110011;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_ZFR  = 4'b0100,
        ALU_LI   = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_XOR  = 4'b1010,
        ALU_NOR  = 4'b1011,
        ALU_MULT = 4'b1100,
        ALU_DIV  = 4'b1101
    } alu_code_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/aludec_table.sv
// Combinational aluop/funct lookup producing the 4-bit ALU code plus
// multicycle and illegal flags.
module aludec_table
    import aludec_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output alu_code_t  code,
    output logic       multicycle,
    output logic       illegal
);

    always_comb begin
        code       = ALU_AND;
        multicycle = 1'b0;
        illegal    = 1'b0;
        case (aluop)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_LI:  code = ALU_LI;
            default: begin
                case (funct)
                    FUNCT_ADD:  code = ALU_ADD;
                    FUNCT_SUB:  code = ALU_SUB;
                    FUNCT_AND:  code = ALU_AND;
                    FUNCT_OR:   code = ALU_OR;
                    FUNCT_SLT:  code = ALU_SLT;
                    FUNCT_SLL:  code = ALU_SLL;
                    FUNCT_ZFR:  code = ALU_ZFR;
                    FUNCT_SRL:  code = ALU_SRL;
                    FUNCT_SRA:  code = ALU_SRA;
                    FUNCT_XOR:  code = ALU_XOR;
                    FUNCT_NOR:  code = ALU_NOR;
                    FUNCT_MULT: begin
                        code       = ALU_MULT;
                        multicycle = 1'b1;
                    end
                    FUNCT_DIV: begin
                        code       = ALU_DIV;
                        multicycle = 1'b1;
                    end
                    default:    illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/aludec_seq.sv
// Handshaked ALU-control decoder with multi-cycle MULT/DIV sequencing.
// Define ALUDEC_SEQ_PERF_EN to add saturating accept/illegal counters.
module aludec_seq
    import aludec_pkg::*;
#(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        funct,
    input  logic [1:0]        aluop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              multicycle,
    output logic              illegal,
    output logic              busy
`ifdef ALUDEC_SEQ_PERF_EN
    ,
    output logic [15:0]       perf_ops,
    output logic [15:0]       perf_illegal
`endif
);

    generate
        if (CTRL_W < 4) begin : g_bad_ctrl_w
            $error("aludec_seq: CTRL_W must be >= 4");
        end
        if (MUL_CYCLES < 1 || MUL_CYCLES > 255) begin : g_bad_mul
            $error("aludec_seq: MUL_CYCLES must be in 1..255");
        end
        if (DIV_CYCLES < 1 || DIV_CYCLES > 255) begin : g_bad_div
            $error("aludec_seq: DIV_CYCLES must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] MUL_CNT = 8'(MUL_CYCLES);
    localparam logic [7:0] DIV_CNT = 8'(DIV_CYCLES);

    alu_code_t dec_code;
    logic      dec_mc;
    logic      dec_ill;

    aludec_table u_table (
        .aluop      (aluop),
        .funct      (funct),
        .code       (dec_code),
        .multicycle (dec_mc),
        .illegal    (dec_ill)
    );

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               mc_q, mc_d;
    logic               ill_q, ill_d;
    logic               accept;
    logic [7:0]         op_cycles;

    assign in_ready   = (state_q == IDLE) || (state_q == HOLD && out_ready);
    assign accept     = in_valid && in_ready;
    assign op_cycles  = (dec_code == ALU_DIV) ? DIV_CNT : MUL_CNT;
    assign out_valid  = (state_q == HOLD);
    assign busy       = (state_q == ITER);
    assign alucontrol = ctrl_q;
    assign multicycle = mc_q;
    assign illegal    = ill_q;

    // An accept in HOLD overrides the drain to IDLE, giving bubble-free back-to-back results.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        mc_d    = mc_q;
        ill_d   = ill_q;
        case (state_q)
            ITER: begin
                if (cnt_q <= 8'd1) begin
                    state_d = HOLD;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: ;
        endcase
        if (accept) begin
            ctrl_d = CTRL_W'(dec_code);
            mc_d   = dec_mc;
            ill_d  = dec_ill;
            if (dec_mc && op_cycles > 8'd1) begin
                state_d = ITER;
                cnt_d   = op_cycles - 8'd1;
            end else begin
                state_d = HOLD;
                cnt_d   = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            ctrl_q  <= '0;
            mc_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            mc_q    <= mc_d;
            ill_q   <= ill_d;
        end
    end

`ifdef ALUDEC_SEQ_PERF_EN
    logic [15:0] perf_ops_q, perf_ops_d;
    logic [15:0] perf_illegal_q, perf_illegal_d;

    always_comb begin
        perf_ops_d     = perf_ops_q;
        perf_illegal_d = perf_illegal_q;
        if (accept && perf_ops_q != 16'hFFFF) perf_ops_d = perf_ops_q + 16'd1;
        if (accept && dec_ill && perf_illegal_q != 16'hFFFF) perf_illegal_d = perf_illegal_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_ops_q     <= 16'd0;
            perf_illegal_q <= 16'd0;
        end else begin
            perf_ops_q     <= perf_ops_d;
            perf_illegal_q <= perf_illegal_d;
        end
    end

    assign perf_ops     = perf_ops_q;
    assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_aludec_seq.sv
// Self-checking bench for aludec_seq: directed handshake/latency cases
// followed by randomized transactions against a table-driven reference model.
module tb_aludec_seq;

    localparam int CTRL_W     = 4;
    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        funct;
    logic [1:0]        aluop;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alucontrol;
    logic              multicycle;
    logic              illegal;
    logic              busy;
`ifdef ALUDEC_SEQ_PERF_EN
    logic [15:0]       perf_ops;
    logic [15:0]       perf_illegal;
`endif

    int testsRun  = 0;
    int failCount = 0;
    int expOps    = 0;
    int expIll    = 0;

    int unsigned rtypeCode[bit [5:0]];
    bit [5:0]    legalFuncts[13] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                     6'b000000, 6'b110011, 6'b000010, 6'b000011, 6'b100110,
                                     6'b100111, 6'b011000, 6'b011010};

    aludec_seq #(
        .CTRL_W     (CTRL_W),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .funct        (funct),
        .aluop        (aluop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alucontrol   (alucontrol),
        .multicycle   (multicycle),
        .illegal      (illegal),
        .busy         (busy)
`ifdef ALUDEC_SEQ_PERF_EN
        ,
        .perf_ops     (perf_ops),
        .perf_illegal (perf_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference decode: fixed codes for non-R classes, lookup table for R-type.
    task automatic modelDecode(input logic [1:0] op, input logic [5:0] f,
                               output logic [3:0] code, output logic mc,
                               output logic ill, output int lat);
        ill = 1'b0;
        if (op == 2'b00)      code = 4'd2;
        else if (op == 2'b01) code = 4'd6;
        else if (op == 2'b11) code = 4'd5;
        else if (rtypeCode.exists(f)) code = 4'(rtypeCode[f]);
        else begin
            code = 4'd0;
            ill  = 1'b1;
        end
        mc  = (op == 2'b10) && (code == 4'd12 || code == 4'd13);
        lat = !mc ? 1 : (code == 4'd12 ? MUL_CYCLES : DIV_CYCLES);
    endtask

    // One full transaction: accept, latency window, optional downstream stall, drain.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] f, input int stall);
        logic [3:0] expCode;
        logic       expMc;
        logic       expIllegal;
        int         lat;
        modelDecode(op, f, expCode, expMc, expIllegal, lat);
        in_valid  = 1'b1;
        aluop     = op;
        funct     = f;
        out_ready = (stall == 0);
        checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
        tick();
        expOps++;
        if (expIllegal) expIll++;
        in_valid = 1'b0;
        aluop    = 2'($urandom);
        funct    = 6'($urandom);
        for (int k = 1; k < lat; k++) begin
            checkOutput("busy_iter", {31'd0, busy}, 32'd1);
            checkOutput("in_ready_iter", {31'd0, in_ready}, 32'd0);
            checkOutput("out_valid_iter", {31'd0, out_valid}, 32'd0);
            tick();
        end
        checkOutput("out_valid_done", {31'd0, out_valid}, 32'd1);
        checkOutput("busy_done", {31'd0, busy}, 32'd0);
        checkOutput("alucontrol", {28'd0, alucontrol}, {28'd0, expCode});
        checkOutput("multicycle", {31'd0, multicycle}, {31'd0, expMc});
        checkOutput("illegal", {31'd0, illegal}, {31'd0, expIllegal});
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            aluop    = 2'($urandom);
            funct    = 6'($urandom);
            checkOutput("in_ready_stall", {31'd0, in_ready}, 32'd0);
            tick();
            checkOutput("out_valid_stall", {31'd0, out_valid}, 32'd1);
            checkOutput("alucontrol_stall", {28'd0, alucontrol}, {28'd0, expCode});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("out_valid_drain", {31'd0, out_valid}, 32'd0);
        checkOutput("in_ready_drain", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rtypeCode[6'b100000] = 2;  rtypeCode[6'b100010] = 6;  rtypeCode[6'b100100] = 0;
        rtypeCode[6'b100101] = 1;  rtypeCode[6'b101010] = 7;  rtypeCode[6'b000000] = 3;
        rtypeCode[6'b110011] = 4;  rtypeCode[6'b000010] = 8;  rtypeCode[6'b000011] = 9;
        rtypeCode[6'b100110] = 10; rtypeCode[6'b100111] = 11; rtypeCode[6'b011000] = 12;
        rtypeCode[6'b011010] = 13;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluop     = 2'b00;
        funct     = 6'b000000;
        #12;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_alucontrol", {28'd0, alucontrol}, 32'd0);
        checkOutput("rst_multicycle", {31'd0, multicycle}, 32'd0);
        checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Back-to-back add then xor with no bubble.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        aluop     = 2'b10;
        funct     = 6'b100000;
        tick();
        expOps++;
        checkOutput("b2b_add_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("b2b_add_code", {28'd0, alucontrol}, 32'h2);
        checkOutput("b2b_add_illegal", {31'd0, illegal}, 32'd0);
        checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        funct = 6'b100110;
        tick();
        expOps++;
        checkOutput("b2b_xor_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("b2b_xor_code", {28'd0, alucontrol}, 32'hA);
        in_valid = 1'b0;
        tick();
        checkOutput("b2b_drain", {31'd0, out_valid}, 32'd0);

        applyStimulus(2'b10, 6'b011000, 0);
        applyStimulus(2'b10, 6'b011010, 0);
        applyStimulus(2'b10, 6'b000011, 5);
        applyStimulus(2'b10, 6'b111111, 0);
        applyStimulus(2'b11, 6'($urandom), 0);

        // Reset in the middle of a divide must clear everything asynchronously.
        in_valid  = 1'b1;
        aluop     = 2'b10;
        funct     = 6'b011010;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("div_busy_c3", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        expOps = 0;
        expIll = 0;
        checkOutput("arst_busy", {31'd0, busy}, 32'd0);
        checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("arst_alucontrol", {28'd0, alucontrol}, 32'd0);
        checkOutput("arst_multicycle", {31'd0, multicycle}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        applyStimulus(2'b10, 6'b100000, 0);

        for (int i = 0; i < 30; i++) begin
            logic [5:0] f;
            if ($urandom_range(0, 3) == 0) f = 6'($urandom);
            else f = legalFuncts[$urandom_range(0, 12)];
            applyStimulus(2'($urandom_range(0, 3)), f, int'($urandom_range(0, 3)));
        end

`ifdef ALUDEC_SEQ_PERF_EN
        checkOutput("perf_ops", {16'd0, perf_ops}, 32'(expOps));
        checkOutput("perf_illegal", {16'd0, perf_illegal}, 32'(expIll));
        force dut.perf_ops_q = 16'hFFFF;
        #1;
        release dut.perf_ops_q;
        applyStimulus(2'b00, 6'b000000, 0);
        checkOutput("perf_ops_sat", {16'd0, perf_ops}, 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/aludec_seq.md
Name: aludec_seq

Overview:
- Parametrised, handshaked successor to the combinational ALU-control decoder in the MIPS datapath.
- Decodes aluop/funct into a widened ALU control code.
- Extends the op set with SRL, SRA, XOR, NOR, MULT and DIV.
- Registers its result behind a valid/ready handshake; MULT and DIV are sequenced as multi-cycle ops, with busy held for a parametrised number of cycles.
- Sits between the main control decoder and the ALU/muldiv execute stage.

Parameters:
- CTRL_W, 4: alucontrol width. Must be >= 4; elaboration-time assertion fails otherwise. Codes are zero-extended to CTRL_W.
- MUL_CYCLES, 4: total cycles from accept to out_valid for MULT. Range 1..255.
- DIV_CYCLES, 8: total cycles from accept to out_valid for DIV. Range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  block can accept this cycle.
- funct  in  6  instruction funct field.
- aluop  in  2  main-decoder ALU op class.
- out_valid  out  1  registered result valid.
- out_ready  in  1  downstream accepts result.
- alucontrol  out  CTRL_W  decoded ALU control.
- multicycle  out  1  result belongs to MULT/DIV.
- illegal  out  1  funct not recognised (R-type only).
- busy  out  1  iteration in progress.

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, alucontrol=0, multicycle=0, illegal=0, busy=0, counter=0.
- Decode, aluop=00/01/11: add 0010 / sub 0110 / LI 0101. funct is ignored.
- Decode, aluop=10, funct:
  - 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 101010 slt 0111.
  - 000000 sll 0011; 110011 zfr 0100.
  - 000010 srl 1000; 000011 sra 1001; 100110 xor 1010; 100111 nor 1011.
  - 011000 mult 1100 (multicycle); 011010 div 1101 (multicycle).
  - Any other funct: illegal=1, alucontrol=0, single-cycle.
- Accept: occurs when in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This gives pass-through for back-to-back requests.
- States:
  - IDLE: on accept of a single-cycle op, go to HOLD; outputs are loaded at that edge, so latency is 1 cycle. On accept of a multicycle op with N>1, go to ITER and set counter=N-1. If N==1, go directly to HOLD.
  - ITER: busy=1, out_valid=0, in_ready=0. Counter decrements each cycle. When counter==1, go to HOLD, so out_valid rises exactly N cycles after accept.
  - HOLD: out_valid=1. Outputs stay stable until out_ready.
    - out_ready && new accept: follow the IDLE rules, without a bubble.
    - out_ready && no accept: go to IDLE, out_valid=0.
- alucontrol, multicycle and illegal are registered and never change while out_valid && !out_ready.
- Inputs in a non-accept cycle are ignored.
- reset_n asserted mid-ITER or mid-HOLD aborts the operation immediately; no output survives.
- illegal is a normal result (handshaked); the block never stalls on it.

Optional Feature:
- Macro: ALUDEC_SEQ_PERF_EN.
- When defined, adds outputs perf_ops[15:0] and perf_illegal[15:0].
  - perf_ops increments on every accept.
  - perf_illegal increments on every accept that decodes illegal.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package aludec_pkg holds:
  - aluop constants (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_LI);
  - funct localparams for all 13 ops;
  - a 4-bit alu_code_t enum with the codes above;
  - state enum {IDLE, ITER, HOLD}.
- Sub-module aludec_table: purely combinational aluop/funct -> {code, multicycle, illegal} lookup, instantiated once. The parent holds the FSM, counter and output registers.

Test Plan:
- Reset, then aluop=10, funct=100000, in_valid=1, out_ready=1 -> next cycle out_valid=1, alucontrol=0010, illegal=0; in_ready stays 1 and back-to-back xor (100110) gives 1010 the following cycle.
- aluop=10, funct=011000 (mult), MUL_CYCLES=4 -> busy=1 and in_ready=0 for cycles 1..3; out_valid=1, alucontrol=1100, multicycle=1 at cycle 4. Repeat with div, DIV_CYCLES=8 -> out_valid at cycle 8.
- out_ready=0 for 5 cycles after an sra (000011) result -> alucontrol held at 1001, in_ready=0 throughout; raising out_ready releases it.
- aluop=10, funct=111111 -> out_valid with illegal=1, alucontrol=0. Then aluop=11, any funct -> 0101, illegal=0.
- Drop reset_n during ITER of div at cycle 3 -> all outputs 0 asynchronously; after release, a new add completes in 1 cycle.
- With ALUDEC_SEQ_PERF_EN: 3 legal + 2 illegal accepts -> perf_ops=5, perf_illegal=2. Forcing perf_ops to 16'hFFFF then one more accept -> value stays 16'hFFFF.
